// File: rtl/mux4b_rr_arbiter.sv
// Round-robin arbiter that shares one enabled 4-bit 4:1 mux among four requesters.
// The owner is rotated when it releases, or after MAX_HOLD cycles if another requester is waiting.

module mux4b_4to1_en (
    input  logic [3:0] d0_i,
    input  logic [3:0] d1_i,
    input  logic [3:0] d2_i,
    input  logic [3:0] d3_i,
    input  logic [1:0] sel_i,
    input  logic       en_i,
    output logic [3:0] y_o
);
    always_comb begin
        y_o = 4'b0000;
        if (en_i) begin
            unique case (sel_i)
                2'd0:    y_o = d0_i;
                2'd1:    y_o = d1_i;
                2'd2:    y_o = d2_i;
                default: y_o = d3_i;
            endcase
        end
    end
endmodule

module mux4b_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       enable,
    output logic [3:0] out,
    output logic [3:0] hold_cnt
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       en_q, en_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] last_q, last_d;
    logic [3:0] others;
    logic [1:0] win_idle, win_next;

    // First asserted request scanning from+1, from+2, from+3, from (mod 4).
    function automatic logic [1:0] pick(input logic [1:0] from, input logic [3:0] mask);
        logic       found;
        logic [1:0] idx;
        found = 1'b0;
        pick  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = from + 2'(k);
            if (!found && mask[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    endfunction

    assign others   = req & ~grant_q;
    assign win_idle = pick(last_q, req);
    assign win_next = pick(sel_q, others);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        en_d    = en_q;
        hold_d  = hold_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << win_idle;
                    sel_d   = win_idle;
                    en_d    = 1'b1;
                    hold_d  = 4'd1;
                end
            end
            GRANT: begin
                if (!req[sel_q] || (hold_q >= MAX_HOLD_C && |others)) begin
                    // Release or forced rotation: hand off directly when anyone else waits.
                    last_d = sel_q;
                    if (|others) begin
                        grant_d = 4'b0001 << win_next;
                        sel_d   = win_next;
                        hold_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        sel_d   = 2'd0;
                        en_d    = 1'b0;
                        hold_d  = 4'd0;
                    end
                end else if (hold_q < MAX_HOLD_C) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            en_q    <= 1'b0;
            hold_q  <= 4'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign enable   = en_q;
    assign hold_cnt = hold_q;

    mux4b_4to1_en u_mux (
        .d0_i  (a),
        .d1_i  (b),
        .d2_i  (c),
        .d3_i  (d),
        .sel_i (sel_q),
        .en_i  (en_q),
        .y_o   (out)
    );
endmodule

// File: tb/tb_mux4b_rr_arbiter.sv
// Bench for mux4b_rr_arbiter: directed cycle table, a saturation/rotation sequence,
// then random traffic against an owner/counter/pointer reference model.

module tb_mux4b_rr_arbiter;
    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, a, b, c, d;
    logic [3:0] grant, out, hold_cnt;
    logic [1:0] sel;
    logic       enable;

    int total  = 0;
    int passed = 0;

    mux4b_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .grant    (grant),
        .sel      (sel),
        .enable   (enable),
        .out      (out),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req, a, b, c, d;
        logic [3:0] g;
        logic [1:0] s;
        logic       en;
        logic [3:0] o;
        logic [3:0] h;
    } vec_t;

    vec_t vq[$];

    task automatic push(input logic r, input logic [3:0] rq, input logic [3:0] da, db, dc, dd,
                        input logic [3:0] g, input logic [1:0] s, input logic en,
                        input logic [3:0] o, input logic [3:0] h);
        vec_t v;
        v.rst = r; v.req = rq; v.a = da; v.b = db; v.c = dc; v.d = dd;
        v.g = g; v.s = s; v.en = en; v.o = o; v.h = h;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] da, db, dc, dd);
        rst = r; req = rq; a = da; b = db; c = dc; d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s, input logic en,
                           input logic [3:0] o, input logic [3:0] h);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".enable"}, 32'(enable), 32'(en));
        chk({tag, ".out"}, 32'(out), 32'(o));
        chk({tag, ".hold"}, 32'(hold_cnt), 32'(h));
        if (g != 4'b0000) chk({tag, ".sel"}, 32'(sel), 32'(s));
    endtask

    // Reference model: owner index (-1 = idle), hold count, round-robin pointer.
    int m_own, m_cnt, m_last;

    function automatic int next_from(input int from, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] rq);
        logic [3:0] oth;
        if (r) begin
            m_own = -1; m_cnt = 0; m_last = 3;
        end else if (m_own < 0) begin
            m_own = next_from(m_last, rq);
            m_cnt = (m_own < 0) ? 0 : 1;
        end else begin
            oth = rq;
            oth[m_own] = 1'b0;
            if (rq[m_own] && (m_cnt < MAXH || oth == 4'b0000)) begin
                m_cnt = (m_cnt < MAXH) ? m_cnt + 1 : MAXH;
            end else begin
                m_last = m_own;
                m_own  = next_from(m_own, oth);
                m_cnt  = (m_own < 0) ? 0 : 1;
            end
        end
    endtask

    initial begin
        logic [3:0] rq, da, db, dc, dd, exp_o;
        logic       r;

        rst = 1'b1; req = 4'b0; a = 4'b0; b = 4'b0; c = 4'b0; d = 4'b0;

        // Reset with all requests high
        push(1, 4'b1111, 1, 2, 3, 4, 4'b0000, 0, 0, 0, 0);
        push(1, 4'b1111, 1, 2, 3, 4, 4'b0000, 0, 0, 0, 0);
        // Single requester, hold saturates, release to idle
        for (int h = 1; h <= 6; h++)
            push(0, 4'b0100, 0, 0, 6, 0, 4'b0100, 2, 1, 6, 4'(h > MAXH ? MAXH : h));
        push(0, 4'b0000, 0, 0, 6, 0, 4'b0000, 0, 0, 0, 0);
        // Fairness with all requesting: owners 0,1,2,3,0 each four cycles
        push(1, 4'b1111, 1, 2, 3, 4, 4'b0000, 0, 0, 0, 0);
        for (int o = 0; o < 5; o++)
            for (int h = 1; h <= MAXH; h++)
                push(0, 4'b1111, 1, 2, 3, 4, 4'b0001 << (o % 4), 2'(o % 4), 1, 4'((o % 4) + 1), 4'(h));
        // Handoff from owner 1 to 3 without a bubble
        push(1, 4'b0000, 0, 5, 0, 9, 4'b0000, 0, 0, 0, 0);
        push(0, 4'b0010, 0, 5, 0, 9, 4'b0010, 1, 1, 5, 1);
        push(0, 4'b1000, 0, 5, 0, 9, 4'b1000, 3, 1, 9, 1);
        // Release to idle, then pointer at 1 gives requester 0 priority over 1
        push(0, 4'b0000, 7, 5, 0, 9, 4'b0000, 0, 0, 0, 0);
        push(0, 4'b0010, 7, 5, 0, 9, 4'b0010, 1, 1, 5, 1);
        push(0, 4'b0000, 7, 5, 0, 9, 4'b0000, 0, 0, 0, 0);
        push(0, 4'b0011, 7, 5, 0, 9, 4'b0001, 0, 1, 7, 1);
        // Reset mid-grant restores pointer to 3
        push(1, 4'b0000, 7, 5, 6, 9, 4'b0000, 0, 0, 0, 0);
        for (int h = 1; h <= 3; h++)
            push(0, 4'b0100, 7, 5, 6, 9, 4'b0100, 2, 1, 6, 4'(h));
        push(1, 4'b0100, 7, 5, 6, 9, 4'b0000, 0, 0, 0, 0);
        push(0, 4'b1010, 7, 5, 6, 9, 4'b0010, 1, 1, 5, 1);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].req, vq[i].a, vq[i].b, vq[i].c, vq[i].d);
            chk_all($sformatf("vec%0d", i), vq[i].g, vq[i].s, vq[i].en, vq[i].o, vq[i].h);
        end

        // Saturated owner yields as soon as a second request appears
        step(1, 4'b0000, 4'h3, 4'hA, 0, 0);
        for (int h = 1; h <= 6; h++) begin
            step(0, 4'b0001, 4'h3, 4'hA, 0, 0);
            chk_all($sformatf("sat%0d", h), 4'b0001, 0, 1, 4'h3, 4'(h > MAXH ? MAXH : h));
        end
        step(0, 4'b0011, 4'h3, 4'hA, 0, 0);
        chk_all("sat_rot", 4'b0010, 1, 1, 4'hA, 1);
        step(0, 4'b0011, 4'h3, 4'hA, 0, 0);
        chk_all("sat_rot2", 4'b0010, 1, 1, 4'hA, 2);

        // Random traffic against the reference model
        model_edge(1'b1, 4'b0000);
        step(1, 4'b0000, 0, 0, 0, 0);
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            da = 4'($urandom); db = 4'($urandom); dc = 4'($urandom); dd = 4'($urandom);
            model_edge(r, rq);
            step(r, rq, da, db, dc, dd);
            case (m_own)
                0: exp_o = da;
                1: exp_o = db;
                2: exp_o = dc;
                3: exp_o = dd;
                default: exp_o = 4'b0000;
            endcase
            chk_all($sformatf("rnd%0d", i), (m_own < 0) ? 4'b0000 : 4'b0001 << m_own,
                    2'(m_own < 0 ? 0 : m_own), m_own >= 0, exp_o, 4'(m_cnt));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
